// File: rtl/sha_msg_padder_if.sv
`default_nettype none
// ============================================================================
// Module      : sha_msg_padder_if
// Description : Handshake bundle between a message source, the SHA-2 message
//               padder and the block consumer (schedule/compression core).
//               Input side : mode, in_valid/in_ready, in_data, in_last,
//                            in_bytes (and bypass when PADDER_BYPASS_EN)
//               Output side: blk_valid/blk_ready, blk_data, blk_first,
//                            blk_last, blk_mode
//               Modports   : master = source/consumer side, slave = padder.
//               Optional   : PADDER_BYPASS_EN adds the bypass signal.
// Revision    : 1.0 - initial release
// ============================================================================
interface sha_msg_padder_if;
    logic          mode;
    logic          in_valid;
    logic          in_ready;
    logic [63:0]   in_data;
    logic          in_last;
    logic [3:0]    in_bytes;
    logic          blk_valid;
    logic          blk_ready;
    logic [1023:0] blk_data;
    logic          blk_first;
    logic          blk_last;
    logic          blk_mode;
`ifdef PADDER_BYPASS_EN
    logic          bypass;

    modport master (
        output mode, in_valid, in_data, in_last, in_bytes, bypass, blk_ready,
        input  in_ready, blk_valid, blk_data, blk_first, blk_last, blk_mode
    );
    modport slave (
        input  mode, in_valid, in_data, in_last, in_bytes, bypass, blk_ready,
        output in_ready, blk_valid, blk_data, blk_first, blk_last, blk_mode
    );
`else
    modport master (
        output mode, in_valid, in_data, in_last, in_bytes, blk_ready,
        input  in_ready, blk_valid, blk_data, blk_first, blk_last, blk_mode
    );
    modport slave (
        input  mode, in_valid, in_data, in_last, in_bytes, blk_ready,
        output in_ready, blk_valid, blk_data, blk_first, blk_last, blk_mode
    );
`endif
endinterface
`default_nettype wire

// File: rtl/sha_msg_padder.sv
`default_nettype none
// ============================================================================
// Module      : sha_msg_padder
// Description : FIPS 180-4 message padder feeding the SHA-2 schedule. Packs a
//               big-endian 64-bit word stream into 512-bit (SHA-256, right
//               aligned in blk_data[511:0]) or 1024-bit (SHA-512) blocks,
//               inserting the 0x80 marker, zero fill and bit length; emits an
//               extra all-padding block when the tail does not fit.
// Ports       : clk, rst_n (async, active low)
//               bus : sha_msg_padder_if.slave (input words / output blocks)
// Optional    : define PADDER_BYPASS_EN to add bus.bypass (raw block packing,
//               no padding, no extra block).
// Revision    : 1.0 - initial release
// ============================================================================
module sha_msg_padder #(
    parameter int LEN_W = 64
) (
    input wire              clk,
    input wire              rst_n,
    sha_msg_padder_if.slave bus
);
    localparam int C_CNT_W = LEN_W - 3;

    typedef enum logic [1:0] {
        S_FILL  = 2'd0,
        S_EMIT  = 2'd1,
        S_EXTRA = 2'd2
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [15:0][63:0]   r_blk;          // element 15 = word slot 0 (MSB end)
    logic [3:0]          r_k;
    logic [C_CNT_W-1:0]  r_bytes;
    logic                r_mode, r_inmsg, r_emitted, r_extra, r_extra_mark;
    logic                r_blk_valid, r_blk_first, r_blk_last, r_blk_mode;

    logic                w_acc, w_hs, w_mode, w_byp, w_pad, w_full, w_done;
    logic                w_fits, w_mark_next, w_need_extra;
    logic [3:0]          w_nmax, w_slot, w_nb, w_add;
    logic [7:0]          w_p;
    logic [63:0]         w_word;
    logic [C_CNT_W-1:0]  w_total;
    logic [127:0]        w_len_new, w_len_cur;
`ifdef PADDER_BYPASS_EN
    logic                r_bypass;
`endif

    // ---------------------------------------------------------------- datapath
    always_comb begin
        w_acc  = bus.in_valid && (r_state == S_FILL);
        w_hs   = r_blk_valid && bus.blk_ready;
        // mode (and bypass) only follow the port on the first word of a message
        w_mode = r_inmsg ? r_mode : bus.mode;
`ifdef PADDER_BYPASS_EN
        w_byp  = r_inmsg ? r_bypass : bus.bypass;
`else
        w_byp  = 1'b0;
`endif
        w_nmax = w_mode ? 4'd15 : 4'd7;
        // SHA-256 blocks occupy the lower half: word k sits in slot k+8
        w_slot = w_mode ? r_k : {1'b1, r_k[2:0]};
        w_nb   = (bus.in_bytes > 4'd8) ? 4'd8 : bus.in_bytes;
        w_full = (r_k == w_nmax);
        w_done = w_acc && (bus.in_last || w_full);
        w_pad  = bus.in_last && !w_byp;

        w_word = bus.in_data;
        if (w_pad) begin
            for (int i = 0; i < 8; i++) begin
                if (4'(i) == w_nb)
                    w_word[63-8*i -: 8] = 8'h80;
                else if (4'(i) > w_nb)
                    w_word[63-8*i -: 8] = 8'h00;
            end
        end

        w_p          = {1'b0, r_k, 3'b000} + {4'b0000, w_nb};
        w_fits       = w_p <= (w_mode ? 8'd111 : 8'd55);
        // a full last word pushes the marker into the following slot
        w_mark_next  = w_pad && (w_nb == 4'd8) && !w_full;
        w_need_extra = w_pad && !w_fits;

        w_add     = bus.in_last ? w_nb : 4'd8;
        w_total   = r_bytes + {{(C_CNT_W-4){1'b0}}, w_add};
        w_len_new = {{(128-LEN_W){1'b0}}, w_total, 3'b000};
        w_len_cur = {{(128-LEN_W){1'b0}}, r_bytes, 3'b000};
    end

    // ---------------------------------------------------------------- FSM
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_FILL:  if (w_done) w_state_nxt = S_EMIT;
            S_EMIT:  if (w_hs)   w_state_nxt = r_extra ? S_EXTRA : S_FILL;
            S_EXTRA: if (w_hs)   w_state_nxt = S_FILL;
            default: w_state_nxt = S_FILL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_FILL;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_blk        <= '0;
            r_k          <= '0;
            r_bytes      <= '0;
            r_mode       <= 1'b0;
            r_inmsg      <= 1'b0;
            r_emitted    <= 1'b0;
            r_extra      <= 1'b0;
            r_extra_mark <= 1'b0;
            r_blk_valid  <= 1'b0;
            r_blk_first  <= 1'b0;
            r_blk_last   <= 1'b0;
            r_blk_mode   <= 1'b0;
`ifdef PADDER_BYPASS_EN
            r_bypass     <= 1'b0;
`endif
        end else begin
            if (w_acc) begin
                r_blk[4'd15 - w_slot] <= w_word;
                if (w_mark_next)
                    r_blk[4'd14 - w_slot] <= 64'h8000_0000_0000_0000;
                if (w_pad && w_fits) begin
                    if (w_mode) r_blk[1:0] <= w_len_new;
                    else        r_blk[0]   <= w_len_new[63:0];
                end
                r_k     <= w_done ? 4'd0 : r_k + 4'd1;
                r_bytes <= w_total;
                r_mode  <= w_mode;
                r_inmsg <= !bus.in_last;
`ifdef PADDER_BYPASS_EN
                r_bypass <= w_byp;
`endif
                if (w_done) begin
                    r_blk_valid  <= 1'b1;
                    r_blk_first  <= !r_emitted;
                    r_blk_last   <= bus.in_last && !w_need_extra;
                    r_blk_mode   <= w_mode;
                    r_emitted    <= !bus.in_last;
                    r_extra      <= w_need_extra;
                    r_extra_mark <= w_pad && (w_nb == 4'd8) && w_full;
                end
            end
            if (w_hs) begin
                r_blk <= '0;
                if (r_state == S_EMIT && r_extra) begin
                    // padding-only tail block, length from the saved byte count
                    if (r_extra_mark)
                        r_blk[r_blk_mode ? 4'd15 : 4'd7] <= 64'h8000_0000_0000_0000;
                    if (r_blk_mode) r_blk[1:0] <= w_len_cur;
                    else            r_blk[0]   <= w_len_cur[63:0];
                    r_blk_first <= 1'b0;
                    r_blk_last  <= 1'b1;
                    r_extra     <= 1'b0;
                end else begin
                    r_blk_valid <= 1'b0;
                    r_blk_first <= 1'b0;
                    r_blk_last  <= 1'b0;
                end
                if (r_blk_last)
                    r_bytes <= '0;
            end
        end
    end

    assign bus.in_ready  = (r_state == S_FILL);
    assign bus.blk_valid = r_blk_valid;
    assign bus.blk_data  = r_blk;
    assign bus.blk_first = r_blk_first;
    assign bus.blk_last  = r_blk_last;
    assign bus.blk_mode  = r_blk_mode;

endmodule
`default_nettype wire

// File: tb/tb_sha_msg_padder.sv
`default_nettype none
// ============================================================================
// Module      : tb_sha_msg_padder
// Description : Self-checking bench for sha_msg_padder. A byte-level FIPS
//               180-4 padding model builds the expected block stream for each
//               message; randomized messages, input gaps, mid-message mode
//               changes and random downstream stalls are applied, plus the
//               directed abc/empty/boundary, backpressure and reset cases.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sha_msg_padder;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sha_msg_padder_if bus();
    sha_msg_padder #(.LEN_W(64)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct {
        logic [1023:0] data;
        logic          first;
        logic          last;
        logic          mode;
    } blk_t;

    blk_t          exp_q[$];
    blk_t          cons_e;
    int            n_checks = 0;
    int            n_errors = 0;
    bit            force_rdy = 1'b0;
    bit            force_val = 1'b0;
    logic [1023:0] last_data = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: pad the byte string, then cut it into blocks.
    task automatic model_msg(input bit m, input byte unsigned msg[$]);
        byte unsigned pad[$];
        int           blk_b = m ? 128 : 64;
        int           len_b = m ? 16 : 8;
        logic [127:0] lenv;
        blk_t         b;
        int           nblk;
        pad = msg;
        pad.push_back(8'h80);
        while ((pad.size() % blk_b) != blk_b - len_b) pad.push_back(8'h00);
        lenv = 128'(msg.size()) << 3;
        for (int i = len_b - 1; i >= 0; i--) pad.push_back(lenv[8*i +: 8]);
        nblk = pad.size() / blk_b;
        for (int n = 0; n < nblk; n++) begin
            b.data = '0;
            for (int j = 0; j < blk_b; j++)
                b.data[(m ? 1023 : 511) - 8*j -: 8] = pad[n*blk_b + j];
            b.first = (n == 0);
            b.last  = (n == nblk - 1);
            b.mode  = m;
            exp_q.push_back(b);
        end
    endtask

    // Called at a negedge; returns at the negedge after the word is taken.
    task automatic drive_word(input logic [63:0] d, input bit last,
                              input logic [3:0] nb, input bit m);
        int t = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = last;
        bus.in_bytes = nb;
        bus.mode     = m;
        while (!bus.in_ready && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (t >= 300) check("in_ready_timeout", 64'd0, 64'd1);
        @(negedge clk);
    endtask

    task automatic send_msg(input bit m, input byte unsigned msg[$]);
        int          len = msg.size();
        int          nw  = (len == 0) ? 1 : (len + 7) / 8;
        logic [63:0] d;
        logic [3:0]  nb;
        bit          lst;
        model_msg(m, msg);
        @(negedge clk);
        for (int k = 0; k < nw; k++) begin
            if ($urandom_range(0, 4) == 0) begin
                bus.in_valid = 1'b0;
                @(negedge clk);
            end
            d = {$urandom, $urandom};
            for (int j = 0; j < 8; j++)
                if (8*k + j < len) d[63-8*j -: 8] = msg[8*k + j];
            lst = (k == nw - 1);
            nb  = lst ? 4'(len - 8*k) : 4'($urandom_range(0, 15));
            if (lst && nb == 4'd8) nb = 4'($urandom_range(8, 15));
            // only the first word's mode may matter
            drive_word(d, lst, nb, (k == 0) ? m : 1'($urandom_range(0, 1)));
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 2000) check("drain_timeout", 64'(exp_q.size()), 64'd0);
        @(negedge clk);
    endtask

    task automatic wait_valid();
        int t = 0;
        while (!bus.blk_valid && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) check("blk_valid_timeout", 64'd0, 64'd1);
    endtask

    // Downstream consumer and scoreboard.
    always @(negedge clk) begin
        if (force_rdy) bus.blk_ready = force_val;
        else           bus.blk_ready = ($urandom_range(0, 3) != 0);
        if (rst_n && bus.blk_valid && bus.blk_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_block", 64'd1, 64'd0);
            end else begin
                cons_e = exp_q.pop_front();
                for (int w = 0; w < 16; w++)
                    check($sformatf("blk_data_w%0d", w), bus.blk_data[1023-64*w -: 64],
                          cons_e.data[1023-64*w -: 64]);
                check("blk_first", 64'(bus.blk_first), 64'(cons_e.first));
                check("blk_last",  64'(bus.blk_last),  64'(cons_e.last));
                check("blk_mode",  64'(bus.blk_mode),  64'(cons_e.mode));
            end
            last_data = bus.blk_data;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        byte unsigned q[$];
        logic [63:0]  hold_hi, hold_lo;
        int           lens[10] = '{0, 55, 56, 63, 64, 111, 112, 119, 127, 128};
        int           len;

        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.in_last  = 1'b0;
        bus.in_bytes = '0;
        bus.mode     = 1'b0;
`ifdef PADDER_BYPASS_EN
        bus.bypass   = 1'b0;
`endif
        #12;
        check("rst_blk_valid", 64'(bus.blk_valid), 64'd0);
        check("rst_blk_first", 64'(bus.blk_first), 64'd0);
        check("rst_blk_last",  64'(bus.blk_last),  64'd0);
        check("rst_blk_mode",  64'(bus.blk_mode),  64'd0);
        check("rst_blk_hi",    bus.blk_data[1023:960], 64'd0);
        check("rst_blk_lo",    bus.blk_data[63:0],     64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("in_ready_after_reset", 64'(bus.in_ready), 64'd1);

        // SHA-256 "abc"
        q = '{8'h61, 8'h62, 8'h63};
        send_msg(1'b0, q);
        wait_drain();
        check("abc256_w0",  last_data[511:448],  64'h6162638000000000);
        check("abc256_len", last_data[63:0],     64'h18);
        check("abc256_top", last_data[1023:960], 64'h0);

        // SHA-512 "abc"
        send_msg(1'b1, q);
        wait_drain();
        check("abc512_w0",  last_data[1023:960], 64'h6162638000000000);
        check("abc512_lhi", last_data[127:64],   64'h0);
        check("abc512_len", last_data[63:0],     64'h18);

        // empty SHA-256
        q.delete();
        send_msg(1'b0, q);
        wait_drain();
        check("empty_w0", last_data[511:448], 64'h8000000000000000);

        // 56 and 64 byte SHA-256 messages (two blocks each)
        q.delete();
        for (int i = 0; i < 56; i++) q.push_back(8'($urandom));
        send_msg(1'b0, q);
        wait_drain();
        check("m56_len", last_data[63:0], 64'h1C0);
        for (int i = 0; i < 8; i++) q.push_back(8'($urandom));
        send_msg(1'b0, q);
        wait_drain();
        check("m64_w0",  last_data[511:448], 64'h8000000000000000);
        check("m64_len", last_data[63:0],    64'h200);

        // backpressure: block must hold for 5 stalled cycles
        @(posedge clk); #1;
        force_rdy = 1'b1;
        force_val = 1'b0;
        q = '{8'h61, 8'h62, 8'h63};
        send_msg(1'b0, q);
        wait_valid();
        hold_hi = bus.blk_data[511:448];
        hold_lo = bus.blk_data[63:0];
        for (int c = 0; c < 5; c++) begin
            check("bp_valid",    64'(bus.blk_valid),    64'd1);
            check("bp_in_ready", 64'(bus.in_ready),     64'd0);
            check("bp_hi",       bus.blk_data[511:448], hold_hi);
            check("bp_lo",       bus.blk_data[63:0],    hold_lo);
            @(negedge clk);
        end
        @(posedge clk); #1;
        force_val = 1'b1;
        wait_drain();
        force_rdy = 1'b0;
        check("bp_in_ready_after", 64'(bus.in_ready), 64'd1);

        // reset after three words of an unfinished message
        @(negedge clk);
        for (int k = 0; k < 3; k++) drive_word({$urandom, $urandom}, 1'b0, 4'd8, 1'b0);
        bus.in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_valid", 64'(bus.blk_valid), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_mid_in_ready", 64'(bus.in_ready), 64'd1);
        check("rst_mid_valid2",   64'(bus.blk_valid), 64'd0);

        // reset while a block is waiting downstream
        @(posedge clk); #1;
        force_rdy = 1'b1;
        force_val = 1'b0;
        send_msg(1'b1, q);
        wait_valid();
        check("pre_rst_valid", 64'(bus.blk_valid), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_blk_valid2", 64'(bus.blk_valid), 64'd0);
        check("rst_blk_first2", 64'(bus.blk_first), 64'd0);
        check("rst_blk_mode2",  64'(bus.blk_mode),  64'd0);
        check("rst_blk_hi2",    bus.blk_data[1023:960], 64'd0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        force_rdy = 1'b0;
        send_msg(1'b0, q);
        wait_drain();
        check("post_rst_w0",  last_data[511:448], 64'h6162638000000000);
        check("post_rst_len", last_data[63:0],    64'h18);

        // randomized messages, biased toward padding boundaries
        for (int n = 0; n < 30; n++) begin
            q.delete();
            len = ($urandom_range(0, 1) == 0) ? lens[$urandom_range(0, 9)]
                                              : int'($urandom_range(0, 300));
            for (int i = 0; i < len; i++) q.push_back(8'($urandom));
            send_msg(1'($urandom_range(0, 1)), q);
            if ($urandom_range(0, 1) == 0) wait_drain();
        end
        wait_drain();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/sha_msg_padder.md
Name: sha_msg_padder

Overview:
Upstream feeder for the SHA-2 message schedule / compression core. Accepts a byte-packed 64-bit message stream with valid/ready handshake and applies FIPS 180-4 padding (0x80 marker, zero fill, big-endian bit length). Emits complete 1024-bit blocks (SHA-512, mode=1) or 512-bit blocks right-aligned in blk_data[511:0] (SHA-256, mode=0), in the exact layout the schedule consumes as M.

Parameters:
LEN_W, 64, width of message bit-length counter; the SHA-512 length field upper 128-LEN_W bits are always zero.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous, active-low reset
mode  in  1  1=SHA-512, 0=SHA-256; sampled with first accepted word of a message
in_valid  in  1  input word valid
in_ready  out  1  padder can accept a word
in_data  in  64  message bytes, big-endian (byte 0 = in_data[63:56])
in_last  in  1  final word of message
in_bytes  in  4  valid bytes in the last word, 0..8; ignored unless in_last (non-last words = 8)
blk_valid  out  1  block available
blk_ready  in  1  downstream accepts block
blk_data  out  1024  block; SHA-256 uses [511:0], [1023:512]=0
blk_first  out  1  block is first of its message
blk_last  out  1  block is final of its message
blk_mode  out  1  latched mode of the message owning the block

Behaviour:
- States: FILL, EMIT, EXTRA. Reset: state=FILL, word index k=0, byte count=0, blk_valid=0, blk_data=0, blk_first=0, blk_last=0, blk_mode=0; in_ready=1 from first clock after reset release.
- in_ready = (state==FILL). Word accepted on in_valid&in_ready.
- N = 16 words/block (mode=1) or 8 (mode=0); BLK=8N bytes; LEN = 16 bytes (mode=1) or 8 (mode=0).
- Word k placed at blk_data[1023-64k -: 64] (mode=1) or [511-64k -: 64] (mode=0); SHA-256 word pairs therefore land upper-32 first.
- Byte counter += 8 per non-last word, += in_bytes on last; wraps mod 2^(LEN_W-3). Bit length = bytes<<3.
- Non-last word with k=N-1: state->EMIT, k=0.
- Last word: bytes beyond in_bytes zeroed; pad position p=8k+in_bytes. If p <= BLK-LEN-1: 0x80 at byte p, zeros to length field, bit length in final LEN bytes (big-endian), blk_last=1, ->EMIT. Else: 0x80 at byte p if p<BLK, rest zero, blk_last=0, ->EMIT with pending EXTRA flag.
- EXTRA block content: all zero, 0x80 at byte 0 only if p==BLK, bit length in final LEN bytes; blk_last=1, blk_first=0.
- blk_first=1 on the first block after a message start (also single-block messages).
- EMIT: blk_valid=1 registered, asserted the cycle after the completing word is accepted; blk_data/blk_first/blk_last/blk_mode stable until blk_valid&blk_ready. On handshake: if EXTRA pending -> EXTRA (blk_valid stays 1 next cycle with new block); else ->FILL, blk_valid=0, block register cleared.
- EXTRA: held until handshake, then ->FILL, counters and byte count cleared after blk_last handshake.
- mode changes mid-message ignored. in_bytes>8 treated as 8. in_last with in_bytes=0 at k=0 = empty message.
- Async reset at any point aborts message: outputs to reset values immediately, partial block discarded.

Optional Feature:
PADDER_BYPASS_EN: adds input port bypass (1 bit, latched with mode). When bypass=1: no 0x80/length insertion, in_bytes ignored, block emitted when full or on in_last (remaining words zero), blk_last on the block holding in_last, never an EXTRA block. Without the macro: port absent, padding always applied.

Test Plan:
SHA-256 "abc": mode=0, in_data=0x6162630000000000, in_bytes=3, in_last -> one block, blk_data[511:448]=0x6162638000000000, [447:64]=0, [63:0]=0x18, blk_first=blk_last=1.
SHA-512 "abc": mode=1, same word -> blk_data[1023:960]=0x6162638000000000, [127:64]=0, [63:0]=0x18, blk_mode=1.
Empty SHA-256: in_bytes=0, in_last at k=0 -> blk_data[511:448]=0x8000000000000000, remaining 0.
SHA-256 56 bytes (7 full words, last in_bytes=8) -> block1 word7=0x8000000000000000, blk_last=0; block2 all zero, [63:0]=0x1C0, blk_last=1. 64 bytes -> block2 word0=0x8000000000000000, [63:0]=0x200.
Backpressure: hold blk_ready=0 for 5 cycles -> blk_valid=1, blk_data constant, in_ready=0 throughout; accepted on cycle 6.
Reset mid-block: assert rst_n=0 after 3 words -> blk_valid=0, in_ready=1 after release; next "abc" message produces correct single block.
